// File: rtl/clock_pattern_generator_pkg.sv
// -----------------------------------------------------------------------------
// clks_alot_pkg
//   Shared types for the clock pattern generator:
//     sys_dom_t   - clock domain bundle (clk, asynchronous active-high rst)
//     gen_state_t - generator FSM states
//     gen_cfg_t   - high rate, low rate and drift direction (shadow/active)
//   floor_one() maps a zero rate to 1 so every phase lasts at least a cycle.
// -----------------------------------------------------------------------------
package clks_alot_pkg;

    // Width of the rate fields held in the configuration struct.
    localparam int unsigned CFG_RATE_WIDTH = 16;

    typedef struct packed {
        logic clk;
        logic rst;
    } sys_dom_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } gen_state_t;

    typedef struct packed {
        logic [CFG_RATE_WIDTH-1:0] high_rate;
        logic [CFG_RATE_WIDTH-1:0] low_rate;
        logic                      direction;
    } gen_cfg_t;

    localparam gen_cfg_t CFG_RESET = '{
        high_rate: CFG_RATE_WIDTH'(1),
        low_rate:  CFG_RATE_WIDTH'(1),
        direction: 1'b0
    };

    function automatic logic [CFG_RATE_WIDTH-1:0] floor_one(
        input logic [CFG_RATE_WIDTH-1:0] rate
    );
        return (rate == '0) ? CFG_RATE_WIDTH'(1) : rate;
    endfunction

endpackage

// File: rtl/clock_pattern_generator_drift_injector.sv
// -----------------------------------------------------------------------------
// drift_injector
//   Counts period starts while drift is enabled and, every Nth period, marks
//   that period's low phase as drift-adjusted by +/-1 cycle.
//   Ports:
//     i_clk, i_rst      - clock, asynchronous active-high reset
//     i_period_start    - strobe on the cycle the generator enters HIGH
//     i_drift_en        - drift enable; low clears the interval counter
//     i_interval        - inject every Nth period (0 treated as 1)
//     i_direction       - 1 lengthens, 0 shortens (from the active config)
//     i_base_low        - active low rate (already floored at 1)
//     o_low_len         - low phase length for the current period
//     o_applied         - current period carries a drift adjustment
// -----------------------------------------------------------------------------
module drift_injector #(
    parameter int unsigned RATE_WIDTH           = 16,
    parameter int unsigned DRIFT_INTERVAL_WIDTH = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_period_start,
    input  logic                            i_drift_en,
    input  logic [DRIFT_INTERVAL_WIDTH-1:0] i_interval,
    input  logic                            i_direction,
    input  logic [RATE_WIDTH-1:0]           i_base_low,
    output logic [RATE_WIDTH-1:0]           o_low_len,
    output logic                            o_applied
);

    localparam int unsigned CW = DRIFT_INTERVAL_WIDTH + 1;

    logic [DRIFT_INTERVAL_WIDTH-1:0] r_count;
    logic                            r_applied;

    logic [DRIFT_INTERVAL_WIDTH-1:0] w_interval;
    logic [CW-1:0]                   w_count_inc;
    logic                            w_hit;
    logic [RATE_WIDTH-1:0]           w_lengthen;
    logic [RATE_WIDTH-1:0]           w_shorten;

    assign w_interval  = (i_interval == '0) ? DRIFT_INTERVAL_WIDTH'(1) : i_interval;
    // One extra bit so the increment can never wrap before the compare.
    assign w_count_inc = {1'b0, r_count} + CW'(1);
    assign w_hit       = (w_count_inc >= {1'b0, w_interval});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count   <= '0;
            r_applied <= 1'b0;
        end else begin
            if (!i_drift_en) begin
                r_count <= '0;
            end else if (i_period_start) begin
                if (w_hit) begin
                    r_count <= '0;
                end else begin
                    r_count <= w_count_inc[DRIFT_INTERVAL_WIDTH-1:0];
                end
            end
            // Decision is held for the whole period it was made for.
            if (i_period_start) begin
                r_applied <= i_drift_en && w_hit;
            end
        end
    end

    // Saturating +/-1: lengthen stops at all-ones, shorten stops at 1.
    assign w_lengthen = (i_base_low == '1) ? i_base_low : i_base_low + RATE_WIDTH'(1);
    assign w_shorten  = (i_base_low <= RATE_WIDTH'(1)) ? RATE_WIDTH'(1)
                                                       : i_base_low - RATE_WIDTH'(1);

    assign o_low_len = r_applied ? (i_direction ? w_lengthen : w_shorten) : i_base_low;
    assign o_applied = r_applied;

endmodule

// File: rtl/clock_pattern_generator.sv
// -----------------------------------------------------------------------------
// clock_pattern_generator
//   Programmable clock source with independent high/low half-periods and
//   optional bounded drift injection on the low phase.
//   Ports:
//     sys_dom_i        - clock domain bundle (.clk, asynchronous active-high .rst)
//     enable_i         - run request, sampled at IDLE and at the end of LOW
//     high_rate_i      - high half-period in clk cycles (0 treated as 1)
//     low_rate_i       - low half-period in clk cycles (0 treated as 1)
//     config_update_i  - capture rates and direction into the shadow config
//     drift_en_i       - enable drift injection
//     drift_direction_i- 1 lengthens, 0 shortens
//     drift_interval_i - inject on every Nth period (0 treated as 1)
//     clk_o            - generated clock
//     rising_edge_o    - pulse on the first HIGH cycle
//     falling_edge_o   - pulse on the first LOW cycle
//     drift_applied_o  - pulse on the first cycle of a drift-adjusted LOW
//     config_pending_o - shadow config not yet transferred to active
//     running_o        - generator not IDLE
// -----------------------------------------------------------------------------
module clock_pattern_generator
    import clks_alot_pkg::*;
#(
    parameter int unsigned RATE_WIDTH           = 16,
    parameter int unsigned DRIFT_INTERVAL_WIDTH = 8
) (
    input  sys_dom_t                        sys_dom_i,
    input  logic                            enable_i,
    input  logic [RATE_WIDTH-1:0]           high_rate_i,
    input  logic [RATE_WIDTH-1:0]           low_rate_i,
    input  logic                            config_update_i,
    input  logic                            drift_en_i,
    input  logic                            drift_direction_i,
    input  logic [DRIFT_INTERVAL_WIDTH-1:0] drift_interval_i,
    output logic                            clk_o,
    output logic                            rising_edge_o,
    output logic                            falling_edge_o,
    output logic                            drift_applied_o,
    output logic                            config_pending_o,
    output logic                            running_o
);

    logic w_clk;
    logic w_rst;

    assign w_clk = sys_dom_i.clk;
    assign w_rst = sys_dom_i.rst;

    gen_state_t            r_state;
    logic [RATE_WIDTH-1:0] r_cnt;
    gen_cfg_t              r_shadow;
    gen_cfg_t              r_active;
    logic                  r_pending;
    logic                  r_clk;
    logic                  r_rise;
    logic                  r_fall;
    logic                  r_drift;
    logic                  r_running;

    gen_cfg_t              w_capture_cfg;
    gen_cfg_t              w_next_cfg;
    logic [RATE_WIDTH-1:0] w_high_len;
    logic [RATE_WIDTH-1:0] w_low_len;
    logic                  w_applied;
    logic                  w_high_done;
    logic                  w_low_done;
    logic                  w_period_start;

    assign w_capture_cfg = '{
        high_rate: floor_one(CFG_RATE_WIDTH'(high_rate_i)),
        low_rate:  floor_one(CFG_RATE_WIDTH'(low_rate_i)),
        direction: drift_direction_i
    };

    // An update coinciding with the period start goes straight into that period.
    assign w_next_cfg = config_update_i ? w_capture_cfg : r_shadow;

    assign w_high_len  = RATE_WIDTH'(r_active.high_rate);
    assign w_high_done = (r_cnt >= w_high_len);
    assign w_low_done  = (r_cnt >= w_low_len);

    assign w_period_start = enable_i &&
                            ((r_state == IDLE) || ((r_state == LOW) && w_low_done));

    drift_injector #(
        .RATE_WIDTH          (RATE_WIDTH),
        .DRIFT_INTERVAL_WIDTH(DRIFT_INTERVAL_WIDTH)
    ) u_drift_injector (
        .i_clk         (w_clk),
        .i_rst         (w_rst),
        .i_period_start(w_period_start),
        .i_drift_en    (drift_en_i),
        .i_interval    (drift_interval_i),
        .i_direction   (r_active.direction),
        .i_base_low    (RATE_WIDTH'(r_active.low_rate)),
        .o_low_len     (w_low_len),
        .o_applied     (w_applied)
    );

    // Phase counter counts up from 1; a phase ends when it reaches its length.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_clk     <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_drift   <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_drift <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable_i) begin
                        r_state   <= HIGH;
                        r_cnt     <= RATE_WIDTH'(1);
                        r_clk     <= 1'b1;
                        r_rise    <= 1'b1;
                        r_running <= 1'b1;
                    end
                end
                HIGH: begin
                    if (w_high_done) begin
                        r_state <= LOW;
                        r_cnt   <= RATE_WIDTH'(1);
                        r_clk   <= 1'b0;
                        r_fall  <= 1'b1;
                        r_drift <= w_applied;
                    end else begin
                        r_cnt <= r_cnt + RATE_WIDTH'(1);
                    end
                end
                LOW: begin
                    if (w_low_done) begin
                        if (enable_i) begin
                            r_state <= HIGH;
                            r_cnt   <= RATE_WIDTH'(1);
                            r_clk   <= 1'b1;
                            r_rise  <= 1'b1;
                        end else begin
                            r_state   <= IDLE;
                            r_cnt     <= '0;
                            r_running <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + RATE_WIDTH'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_cnt     <= '0;
                    r_clk     <= 1'b0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_shadow  <= CFG_RESET;
            r_active  <= CFG_RESET;
            r_pending <= 1'b0;
        end else begin
            if (config_update_i) begin
                r_shadow <= w_capture_cfg;
            end
            if (w_period_start) begin
                r_active  <= w_next_cfg;
                r_pending <= 1'b0;
            end else if (config_update_i) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign clk_o            = r_clk;
    assign rising_edge_o    = r_rise;
    assign falling_edge_o   = r_fall;
    assign drift_applied_o  = r_drift;
    assign config_pending_o = r_pending;
    assign running_o        = r_running;

endmodule

// File: doc/clock_pattern_generator.md
# clock_pattern_generator

Programmable clock source and reference transmitter for the clock-recovery path: emits a clock with independently set high and low half-periods. It can also inject deliberate, bounded drift, so `rate_control` and `drift_tracking` can be driven with a known pattern. It sits at the stimulus/transmit end of the link, and its edge strobes serve as ground truth for the receiver's drift accounting.

## Interface
Parameters:
- `RATE_WIDTH`, default 16, width of the half-period counters.
- `DRIFT_INTERVAL_WIDTH`, default 8, width of the drift-interval counter.

Ports:
- `sys_dom_i` (input, `sys_dom_t`): clock domain bundle carrying `.clk` and `.rst`.
  - One clock.
  - Reset is asynchronous and active-high.
- `enable_i` (input, 1): run request.
- `high_rate_i` (input, RATE_WIDTH): high half-period in clk cycles. 0 is treated as 1.
- `low_rate_i` (input, RATE_WIDTH): low half-period in clk cycles. 0 is treated as 1.
- `config_update_i` (input, 1): pulse that captures `high_rate_i`, `low_rate_i` and `drift_direction_i` into the shadow registers.
- `drift_en_i` (input, 1): enables drift injection.
- `drift_direction_i` (input, 1): 1 lengthens, 0 shortens. Captured with the config.
- `drift_interval_i` (input, DRIFT_INTERVAL_WIDTH): inject on every Nth period. 0 is treated as 1.
- `clk_o` (output, 1): generated clock, registered.
- `rising_edge_o` (output, 1): pulse in the cycle `clk_o` goes 0→1.
- `falling_edge_o` (output, 1): pulse in the cycle `clk_o` goes 1→0.
- `drift_applied_o` (output, 1): pulse at the start of a drift-adjusted low phase.
- `config_pending_o` (output, 1): shadow registers hold values not yet active.
- `running_o` (output, 1): state is not IDLE.

## Operation
States and transitions:
- IDLE: `clk_o`=0. When `enable_i`=1, go to HIGH.
- HIGH: count the active high rate. At terminal count, go to LOW.
- LOW: count the low length. At terminal count:
  - if `enable_i`=1, go to HIGH;
  - otherwise go to IDLE.

Rules:
- **Disable:** takes effect only at the end of a LOW phase. Output never glitches and never truncates a phase.
- **Config transfer:** shadow→active transfer happens only on entry to HIGH (period start).
  - A `config_update_i` in the same cycle as the period start is bypassed into that period.
  - `config_pending_o` rises the cycle after capture and clears on transfer.
- **Drift counting:** the drift counter increments at each period start while `drift_en_i`=1.
  - When the counter reaches the interval, that period's low length becomes low_rate±1 and the counter clears.
  - Lengthen saturates at 2^RATE_WIDTH−1.
  - Shorten floors at 1. At the floor, the low length stays 1, but `drift_applied_o` still pulses.
- **Drift enable off:** deasserting `drift_en_i` clears the drift counter.
- **Drift stability:** drift never alters a high phase. Non-drift periods are exactly high+low.

## Timing
- **Reset values:**
  - All outputs are 0.
  - State is IDLE.
  - Active and shadow rates are 1.
  - Direction is 0.
  - Drift counter is 0.
- **Reset mid-operation:** `clk_o` drops to 0 asynchronously, with no edge pulse.
- **Startup:** with `enable_i` first seen high at cycle t, `clk_o`=1 and `rising_edge_o`=1 at t+1.
- **Phase lengths:** `clk_o` holds high for H cycles and low for L cycles. Period = H+L, with H,L ≥ 1.
- **Edge strobes:** `falling_edge_o` and `drift_applied_o` coincide on the first LOW cycle.
- **Minimum period:** H=L=1 gives a clk/2 output with strobes every cycle alternately.
- **Drift latency:** the drift decision is made at period start. `drift_interval_i` changes take effect at the next period start.

## Structure
- **Package `clks_alot_pkg`:**
  - `gen_state_t` enum (IDLE, HIGH, LOW);
  - a struct bundling the high rate, low rate and direction (shadow/active config).
- **Sub-module `drift_injector`:** owns the interval counter and the saturating ±1 low-length adjustment. Inputs are the period-start strobe, enable, interval, direction and base low rate. Outputs are the adjusted low length and the applied flag.
- **Top level:** holds the FSM, the phase counter and the shadow registers.

## Test plan
- **Basic run:** H=3, L=2, enable.
  - `clk_o` pattern is 11100 repeating.
  - `rising_edge_o` fires every 5 cycles, starting 1 cycle after enable.
- **Zero rates:** H=0, L=0 → clk/2 output. Both strobes alternate every cycle.
- **Mid-period config:** change H=3/L=2 to H=5/L=5 during HIGH.
  - Current period completes as 3+2.
  - Next period is 5+5.
  - `config_pending_o` is high in between.
- **Drift lengthen:** H=4, L=4, drift_en, interval=3, lengthen.
  - Every 3rd period is 4+5 with `drift_applied_o` pulsed.
  - All other periods are 4+4.
- **Drift shorten at floor:** L=1, shorten, interval=1 → low phase stays 1 and `drift_applied_o` pulses each period.
- **Disable and reset:** H=6, L=6.
  - Disable in cycle 2 of HIGH: output finishes 6+6, then goes to IDLE.
  - Async reset during HIGH: `clk_o`=0 immediately and no strobes fire.
